mux3_rr_sel: RTL and testbench

- Round-robin select controller sitting directly upstream of the mux3 merge cell.
- Arbitrates three requesters whose data enters mux3 on i_i[2:0].
- Drives the mux3 2-bit select from a register, so the select is glitch-free and stable for whole transfers.
- Provides a valid/ready handshake toward the consumer of the mux3 output, plus per-requester grant/ack.

---
 rtl/mux3_pkg.sv | 40 ++++
 rtl/rr_pick3.sv | 40 ++++
 rtl/mux3_rr_sel.sv | 131 +++++++++++++
 tb/tb_mux3_rr_sel.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mux3_pkg.sv
`default_nettype none
// ============================================================================
// Module : mux3_pkg
// Brief  : Shared select encodings, state type and helpers for mux3 control.
// Rev    : 1.0
// ============================================================================
package mux3_pkg;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [1:0] onehot3_to_sel(input logic [2:0] oh);
    logic [1:0] sel;
    case (oh)
      3'b010:  sel = SEL_I1;
      3'b100:  sel = SEL_I2;
      default: sel = SEL_I0;
    endcase
    return sel;
  endfunction

  // mod-3 increment; an out-of-range input folds back to 0
  function automatic logic [1:0] ptr_inc3(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// ============================================================================
// Module : rr_pick3
// Brief  : Combinational 3-way round-robin pick starting at a pointer.
// Rev    : 1.0
// ============================================================================
module rr_pick3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] gnt_o,
  output logic       any_o
);

  logic [2:0] rot;
  logic [2:0] pick;

  // rotate so the pointer position lands at bit 0, fixed-priority pick, rotate back
  always_comb begin
    case (ptr_i)
      2'd1:    rot = {req_i[0], req_i[2], req_i[1]};
      2'd2:    rot = {req_i[1], req_i[0], req_i[2]};
      default: rot = req_i;
    endcase

    if (rot[0])      pick = 3'b001;
    else if (rot[1]) pick = 3'b010;
    else if (rot[2]) pick = 3'b100;
    else             pick = 3'b000;

    case (ptr_i)
      2'd1:    gnt_o = {pick[1], pick[0], pick[2]};
      2'd2:    gnt_o = {pick[0], pick[2], pick[1]};
      default: gnt_o = pick;
    endcase
  end

  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/mux3_rr_sel.sv
`default_nettype none
// ============================================================================
// Module : mux3_rr_sel
// Brief  : Round-robin select controller feeding the mux3 select input.
// Rev    : 1.0
// ============================================================================
module mux3_rr_sel
  import mux3_pkg::*;
#(
  parameter int         BURST_LEN = 1,
  parameter logic [1:0] IDLE_SEL  = 2'b00
) (
`ifdef PWR_PINS
  input  logic       VDD,
  input  logic       GND,
`endif
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic       ready_i,
  output logic [1:0] sel_o,
  output logic [2:0] gnt_o,
  output logic       valid_o,
  output logic [2:0] ack_o
);

  localparam logic [3:0] c_BURST_MAX = 4'(BURST_LEN);

  state_e     state_q, state_d;
  logic [2:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [3:0] cnt_q,   cnt_d;

  logic       xfer;
  logic       keep;
  logic [1:0] rot_ptr;
  logic [1:0] pick_ptr;
  logic [2:0] win;
  logic       any;

  assign xfer     = (state_q == GRANT) && ready_i;
  assign keep     = (|(req_i & gnt_q)) && (cnt_q < c_BURST_MAX);
  assign rot_ptr  = ptr_inc3(sel_q);
  // in GRANT the arbiter looks ahead from the post-rotation pointer
  assign pick_ptr = (state_q == GRANT) ? rot_ptr : ptr_q;

  rr_pick3 u_pick (
    .req_i (req_i),
    .ptr_i (pick_ptr),
    .gnt_o (win),
    .any_o (any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          gnt_d   = win;
          sel_d   = onehot3_to_sel(win);
          cnt_d   = 4'd1;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (keep) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            ptr_d = rot_ptr;
            if (any) begin
              gnt_d = win;
              sel_d = onehot3_to_sel(win);
              cnt_d = 4'd1;
            end else begin
              state_d = IDLE;
              gnt_d   = 3'b000;
              sel_d   = IDLE_SEL;
              cnt_d   = 4'd0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        sel_d   = IDLE_SEL;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      sel_q   <= IDLE_SEL;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_o   = sel_q;
  assign gnt_o   = gnt_q;
  assign valid_o = (state_q == GRANT);
  assign ack_o   = gnt_q & {3{valid_o & ready_i}};

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_q));
  a_gnt_valid   : assert property (@(posedge clk_i) disable iff (rst_i)
    ((gnt_q != 3'b000) == valid_o));
  a_sel_match   : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o ? (sel_q == onehot3_to_sel(gnt_q)) : (sel_q == IDLE_SEL)));
  a_sel_legal   : assert property (@(posedge clk_i) disable iff (rst_i)
    (sel_q != 2'b11));
  a_ptr_legal   : assert property (@(posedge clk_i) disable iff (rst_i)
    (ptr_q != 2'd3));

endmodule
`default_nettype wire

// File: tb/tb_mux3_rr_sel.sv
`default_nettype none
// ============================================================================
// Module : tb_mux3_rr_sel
// Brief  : Directed self-checking bench for mux3_rr_sel (burst 1 and 3).
// Rev    : 1.0
// ============================================================================
module tb_mux3_rr_sel;

  logic       clk = 1'b0;
  logic       rst1, rdy1, val1;
  logic [2:0] req1, gnt1, ack1;
  logic [1:0] sel1;
  logic       rst3, rdy3, val3;
  logic [2:0] req3, gnt3, ack3;
  logic [1:0] sel3;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mux3_rr_sel #(.BURST_LEN(1), .IDLE_SEL(2'b00)) dut1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .ready_i(rdy1),
    .sel_o(sel1), .gnt_o(gnt1), .valid_o(val1), .ack_o(ack1)
  );

  mux3_rr_sel #(.BURST_LEN(3), .IDLE_SEL(2'b01)) dut3 (
    .clk_i(clk), .rst_i(rst3), .req_i(req3), .ready_i(rdy3),
    .sel_o(sel3), .gnt_o(gnt3), .valid_o(val3), .ack_o(ack3)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk1(input string tag, input logic [2:0] g, input logic [1:0] s, input logic v);
    chk({tag, ".gnt"},   {1'b0, gnt1}, {1'b0, g});
    chk({tag, ".sel"},   {2'b0, sel1}, {2'b0, s});
    chk({tag, ".valid"}, {3'b0, val1}, {3'b0, v});
  endtask

  task automatic chk3(input string tag, input logic [2:0] g, input logic [1:0] s, input logic v);
    chk({tag, ".gnt"},   {1'b0, gnt3}, {1'b0, g});
    chk({tag, ".sel"},   {2'b0, sel3}, {2'b0, s});
    chk({tag, ".valid"}, {3'b0, val3}, {3'b0, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rr_g [4];
    logic [1:0] rr_s [4];
    logic [2:0] bu_g [7];
    rr_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_s = '{2'b00, 2'b01, 2'b10, 2'b00};
    bu_g = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b001};

    rst1 = 1'b1; req1 = 3'b111; rdy1 = 1'b1;
    rst3 = 1'b1; req3 = 3'b111; rdy3 = 1'b1;

    // reset held two cycles with all requests active
    repeat (2) begin
      tick();
      chk1("rst1", 3'b000, 2'b00, 1'b0);
      chk("rst1.ack", {1'b0, ack1}, 4'b0000);
      chk3("rst3", 3'b000, 2'b01, 1'b0);
    end

    // round robin with BURST_LEN=1
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("rr", rr_g[i], rr_s[i], 1'b1);
      chk("rr.ack", {1'b0, ack1}, {1'b0, rr_g[i]});
    end

    // stall on requester 1 while requests change
    req1 = 3'b010;
    tick();
    chk1("stall.enter", 3'b010, 2'b01, 1'b1);
    rdy1 = 1'b0;
    #1;
    chk("stall.ack0", {1'b0, ack1}, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req1 = 3'b101;
      tick();
      chk1("stall.hold", 3'b010, 2'b01, 1'b1);
      chk("stall.ack", {1'b0, ack1}, 4'b0000);
    end
    rdy1 = 1'b1;
    #1;
    chk("stall.release", {1'b0, ack1}, 4'b0010);
    tick();
    chk1("stall.next", 3'b100, 2'b10, 1'b1);

    // drain to idle, then a single-request pulse
    req1 = 3'b000;
    tick();
    chk1("drain.idle", 3'b000, 2'b00, 1'b0);
    chk("drain.idle.ack", {1'b0, ack1}, 4'b0000);
    req1 = 3'b100;
    tick();
    chk1("pulse.grant", 3'b100, 2'b10, 1'b1);
    req1 = 3'b000;
    #1;
    chk("pulse.ack", {1'b0, ack1}, 4'b0100);
    tick();
    chk1("pulse.idle", 3'b000, 2'b00, 1'b0);
    req1 = 3'b111;
    tick();
    chk1("pulse.ptr0", 3'b001, 2'b00, 1'b1);

    // reset during a stall on requester 2
    req1 = 3'b100;
    tick();
    chk1("mrst.grant", 3'b100, 2'b10, 1'b1);
    rdy1 = 1'b0;
    tick();
    chk1("mrst.hold", 3'b100, 2'b10, 1'b1);
    rst1 = 1'b1;
    rdy1 = 1'b1;
    tick();
    chk1("mrst.reset", 3'b000, 2'b00, 1'b0);
    chk("mrst.ack", {1'b0, ack1}, 4'b0000);
    rst1 = 1'b0;
    req1 = 3'b111;
    tick();
    chk1("mrst.ptr0", 3'b001, 2'b00, 1'b1);

    // bursts of three, then early rotation and drain with IDLE_SEL=01
    rst3 = 1'b0;
    req3 = 3'b011;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk3("burst", bu_g[i], (bu_g[i] == 3'b010) ? 2'b01 : 2'b00, 1'b1);
      chk("burst.ack", {1'b0, ack3}, {1'b0, bu_g[i]});
    end
    req3 = 3'b010;
    tick();
    chk3("burst.early", 3'b010, 2'b01, 1'b1);
    req3 = 3'b000;
    tick();
    chk3("burst.idle", 3'b000, 2'b01, 1'b0);
    chk("burst.idle.ack", {1'b0, ack3}, 4'b0000);
    req3 = 3'b111;
    tick();
    chk3("burst.ptr2", 3'b100, 2'b10, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
